// File: rtl/apb_slave_mem.sv
// apb_slave_mem -- APB completer backed by a word-addressed register memory.
//
// Sits at the far end of the APB segment of the apb2apb bridge and serves as
// the bridge endpoint and bench target. Each transfer takes a fixed number of
// wait states (WAIT_CYCLES) before ready is raised for one cycle.
//
// Ports:
//   clk     in   clock, all logic on posedge
//   rst     in   synchronous reset, active-high
//   sel     in   APB select
//   enable  in   APB enable (access phase)
//   write   in   1 = write, 0 = read
//   strobe  in   byte write enables, sampled in the response cycle
//   addr    in   byte address
//   wdata   in   write data
//   ready   out  transfer completes this cycle
//   rdata   out  read data, valid only while ready=1 on a read
//   slverr  out  error response, valid only while ready=1
//
// Optional feature, macro APB_SLV_ERR_EN:
//   defined   - out-of-range (addr >= DEPTH*4) or misaligned addresses are
//               flagged in setup and answered with slverr=1; a flagged write
//               leaves memory untouched and a flagged read returns 0.
//   undefined - slverr is tied 0, the word index wraps modulo DEPTH and the
//               low two address bits are ignored.
module apb_slave_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int STRB_SIZE   = DATA_WIDTH / 8,
   parameter int DEPTH       = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sel,
   input  logic                  enable,
   input  logic                  write,
   input  logic [STRB_SIZE-1:0]  strobe,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  slverr
);

   localparam int IDX_W = $clog2(DEPTH);
   // WAIT_CYCLES is limited to 0..15, so a 4-bit counter is enough.
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                         state, state_nxt;
   logic [3:0]                     cnt;
   logic [IDX_W-1:0]               idx_q;
   logic                           wr_q;
   logic [DATA_WIDTH-1:0]          wdata_q;
   logic                           err_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

   logic             setup;
   logic [IDX_W-1:0] idx;
   logic             err_in;
   logic             unused_ok;

   assign setup = sel & ~enable;
   // Taking only these bits makes the index wrap modulo DEPTH.
   assign idx   = addr[IDX_W+1:2];

`ifdef APB_SLV_ERR_EN
   assign err_in = (addr >= ADDR_WIDTH'(DEPTH * 4)) || (addr[1:0] != 2'b00);
`else
   assign err_in = 1'b0;
`endif

   // Address bits outside the index are only consulted by the error check.
   assign unused_ok = ^addr;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and outputs; outputs depend on registers only.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      rdata     = '0;
      slverr    = 1'b0;
      case (state)
         IDLE: begin
            // enable=1 without a preceding setup cycle is ignored here
            if (setup) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
         end
         WAIT: begin
            if (!sel)                          state_nxt = IDLE;
            else if (enable && cnt == 4'd1)    state_nxt = RESP;
         end
         RESP: begin
            ready     = 1'b1;
            slverr    = err_q;
            if (!wr_q && !err_q) rdata = mem[idx_q];
            // completes even if the master dropped sel early
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Setup latch, wait counter and memory
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         mem     <= '0;
      end else begin
         if (state == IDLE && setup) begin
            idx_q   <= idx;
            wr_q    <= write;
            wdata_q <= wdata;
            err_q   <= err_in;
            cnt     <= CNT_INIT;
         end else if (state == WAIT && sel && enable) begin
            cnt <= cnt - 4'd1;
         end
         // Write commits at the edge ending RESP; strobe is taken live.
         if (state == RESP && wr_q && !err_q) begin
            for (int i = 0; i < STRB_SIZE; i++)
               if (strobe[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem. Two instances share one APB bus:
// dut_a uses WAIT_CYCLES=2, dut_b uses WAIT_CYCLES=0; each has its own sel.
module tb_apb_slave_mem;

   logic        clk, rst;
   logic        sel_a, sel_b, enable, write;
   logic [3:0]  strobe;
   logic [31:0] addr, wdata;
   logic        ready_a, ready_b, slverr_a, slverr_b;
   logic [31:0] rdata_a, rdata_b;
   bit          use_b;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        rd;
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem_a[16];
   logic [31:0] mem_b[16];

   apb_slave_mem #(.WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .sel(sel_a), .enable(enable), .write(write),
      .strobe(strobe), .addr(addr), .wdata(wdata),
      .ready(ready_a), .rdata(rdata_a), .slverr(slverr_a));

   apb_slave_mem #(.WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .sel(sel_b), .enable(enable), .write(write),
      .strobe(strobe), .addr(addr), .wdata(wdata),
      .ready(ready_b), .rdata(rdata_b), .slverr(slverr_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a);
`ifdef APB_SLV_ERR_EN
      return (a >= 32'd64) || (a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
   endtask

   // Bus idle for one cycle; called at posedge+1.
   task automatic bus_idle();
      sel_a = 0; sel_b = 0; enable = 0; strobe = '0;
      @(posedge clk); #1;
   endtask

   // One complete transfer, entered at posedge+1 and left at posedge+1 after
   // the response edge so another call goes back-to-back.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      exp_t        e;
      logic [3:0]  ix;
      logic [31:0] w;
      int          n;
      bit          done;
      logic        rdy, er;
      logic [31:0] rd;
      ix     = a[5:2];
      e.rd   = !wr;
      e.err  = model_err(a);
      e.lat  = use_b ? 1 : 3;
      e.data = '0;
      if (wr && !e.err) begin
         w = use_b ? mem_b[ix] : mem_a[ix];
         for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
         if (use_b) mem_b[ix] = w; else mem_a[ix] = w;
      end else if (!wr && !e.err) begin
         e.data = use_b ? mem_b[ix] : mem_a[ix];
      end
      sbq.push_back(e);

      sel_a = !use_b; sel_b = use_b; enable = 0;
      write = wr; addr = a; wdata = d; strobe = s;
      @(posedge clk); #1;
      enable = 1;
      n = 1; done = 0; rdy = 0; rd = '0; er = 0;
      while (!done) begin
         @(negedge clk);
         rdy = use_b ? ready_b : ready_a;
         rd  = use_b ? rdata_b : rdata_a;
         er  = use_b ? slverr_b : slverr_a;
         if (rdy || n >= 20) done = 1;
         else begin
            n++;
            @(posedge clk); #1;
         end
      end
      e = sbq.pop_front();
      chk("ready_seen", 32'(rdy), 32'd1);
      chk("latency", n, e.lat);
      if (e.rd) chk("rdata", rd, e.data);
      chk("slverr", 32'(er), 32'(e.err));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1; use_b = 0;
      sel_a = 0; sel_b = 0; enable = 0; write = 0;
      strobe = '0; addr = '0; wdata = '0;
      clear_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_a", 32'(ready_a), 32'd0);
      chk("rst_rdata_a", rdata_a, 32'd0);
      chk("rst_slverr_a", 32'(slverr_a), 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd0);
      @(posedge clk); #1;
      rst = 0;

      // wait-state read of a reset word
      xfer(0, 32'h8, '0, '0);
      bus_idle();
      // full write then read
      xfer(1, 32'h4, 32'hDEADBEEF, 4'b1111);
      bus_idle();
      xfer(0, 32'h4, '0, '0);
      bus_idle();
      // partial strobe, back-to-back read
      xfer(1, 32'h4, 32'h11223344, 4'b0101);
      xfer(0, 32'h4, '0, '0);
      // strobe=0 write changes nothing
      xfer(1, 32'h4, 32'hFFFFFFFF, 4'b0000);
      xfer(0, 32'h4, '0, '0);
      // last word
      xfer(1, 32'h3C, 32'hCAFEF00D, 4'b1111);
      xfer(0, 32'h3C, '0, '0);
      bus_idle();

      // zero wait states, back-to-back
      use_b = 1;
      xfer(1, 32'h0, 32'h000000A5, 4'b1111);
      xfer(0, 32'h0, '0, '0);
      xfer(0, 32'h4, '0, '0);
      bus_idle();
      use_b = 0;

      // enable without setup is ignored
      sel_a = 1; enable = 1; write = 1; addr = 32'h8; wdata = 32'h99; strobe = 4'hF;
      @(negedge clk);
      chk("nosetup_ready", 32'(ready_a), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("nosetup_ready2", 32'(ready_a), 32'd0);
      @(posedge clk); #1;
      bus_idle();

      // abort in WAIT: sel drops, no write
      sel_a = 1; enable = 0; write = 1; addr = 32'h8; wdata = 32'h55; strobe = 4'hF;
      @(posedge clk); #1;
      enable = 1;
      @(negedge clk);
      chk("abort_wait_ready", 32'(ready_a), 32'd0);
      @(posedge clk); #1;
      sel_a = 0; enable = 0;
      @(posedge clk); #1;
      xfer(0, 32'h8, '0, '0);
      bus_idle();

      // reset in the middle of WAIT on a write to 0xC
      sel_a = 1; enable = 0; write = 1; addr = 32'hC; wdata = 32'h77; strobe = 4'hF;
      @(posedge clk); #1;
      enable = 1;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      clear_model();
      @(negedge clk);
      chk("rst_mid_ready", 32'(ready_a), 32'd0);
      chk("rst_mid_rdata", rdata_a, 32'd0);
      @(posedge clk); #1;
      rst = 0; sel_a = 0; enable = 0;
      @(posedge clk); #1;
      xfer(0, 32'hC, '0, '0);
      xfer(0, 32'h4, '0, '0);
      bus_idle();

      // out-of-range and misaligned accesses
      xfer(1, 32'h40, 32'h00001234, 4'b1111);
      bus_idle();
      xfer(0, 32'h0, '0, '0);
      xfer(1, 32'h3C, 32'h0BADF00D, 4'b1111);
      xfer(0, 32'h3D, '0, '0);
      bus_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
